// File: rtl/dbus_master.sv
// dbus_master: load/store bus initiator. It turns one LSU request into one dbus transaction,
// or rejects it as misaligned. Load data is returned aligned and sign- or zero-extended.
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   lsu_req_i .. lsu_wdata_i     request from the LSU stage; sampled only when accepted
//   lsu_ready_o                  high in IDLE; a request is accepted on req & ready at posedge
//   lsu_done_o                   one-cycle completion pulse
//   lsu_rdata_o                  load result, valid while done is high
//   lsu_misalign_o               valid with done: request rejected as misaligned or reserved size
//   lsu_timeout_o                valid with done: no ack within TIMEOUT_CYCLES
//   dbus_cyc_o .. dbus_w_data_o  registered bus request, held stable while in BUS
//   dbus_ack_i, dbus_r_data_i    responder handshake and read data
module dbus_master #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_unsigned_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_ready_o,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_misalign_o,
    output logic            lsu_timeout_o,
    output logic            dbus_cyc_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic            dbus_w_en_o,
    output logic [3:0]      dbus_sel_byte_o,
    output logic [XLEN-1:0] dbus_w_data_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_r_data_i
);

    localparam int unsigned LANES = XLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              w_en_q, w_en_d;
    logic [3:0]        sel_q, sel_d;
    logic [XLEN-1:0]   w_data_q, w_data_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              unsigned_q, unsigned_d;

    logic              misalign_c;
    logic [3:0]        sel_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        lane_b_c;
    logic [15:0]       lane_h_c;
    logic [XLEN-1:0]   load_fmt_c;

    // Alignment check on the incoming request; size 11 is reserved and always rejected.
    always_comb begin
        misalign_c = 1'b0;
        case (lsu_size_i)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = lsu_addr_i[0];
            2'b10:   misalign_c = (lsu_addr_i[1:0] != 2'b00);
            default: misalign_c = 1'b1;
        endcase
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        sel_c   = 4'hF;
        wdata_c = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                sel_c   = 4'(4'b0001 << lsu_addr_i[1:0]);
                wdata_c = {LANES{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_c   = 4'(4'b0011 << lsu_addr_i[1:0]);
                wdata_c = {(LANES/2){lsu_wdata_i[15:0]}};
            end
            default: begin
                sel_c   = 4'hF;
                wdata_c = lsu_wdata_i;
            end
        endcase
    end

    // Extract the addressed lane from read data and extend it.
    always_comb begin
        lane_b_c   = 8'(dbus_r_data_i >> {off_q, 3'b000});
        lane_h_c   = 16'(dbus_r_data_i >> {off_q[1], 4'b0000});
        load_fmt_c = dbus_r_data_i;
        case (size_q)
            2'b00:   load_fmt_c = unsigned_q ? XLEN'(lane_b_c)
                                             : {{(XLEN-8){lane_b_c[7]}}, lane_b_c};
            2'b01:   load_fmt_c = unsigned_q ? XLEN'(lane_h_c)
                                             : {{(XLEN-16){lane_h_c[15]}}, lane_h_c};
            default: load_fmt_c = dbus_r_data_i;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        addr_d     = addr_q;
        w_en_d     = w_en_q;
        sel_d      = sel_q;
        w_data_d   = w_data_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        off_d      = off_q;
        unsigned_d = unsigned_q;
        done_d     = 1'b0;
        rdata_d    = '0;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (misalign_c) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = S_BUS;
                        cyc_d      = 1'b1;
                        addr_d     = {lsu_addr_i[XLEN-1:2], 2'b00};
                        w_en_d     = lsu_we_i;
                        sel_d      = sel_c;
                        w_data_d   = lsu_we_i ? wdata_c : '0;
                        cnt_d      = '0;
                        size_d     = lsu_size_i;
                        off_d      = lsu_addr_i[1:0];
                        unsigned_d = lsu_unsigned_i;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                // Ack takes priority over a timeout on the same edge.
                if (dbus_ack_i || (cnt_q == TMO_W'(TIMEOUT_CYCLES))) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cyc_d     = 1'b0;
                    addr_d    = '0;
                    w_en_d    = 1'b0;
                    sel_d     = '0;
                    w_data_d  = '0;
                    timeout_d = !dbus_ack_i;
                    rdata_d   = (dbus_ack_i && !w_en_q) ? load_fmt_c : '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            addr_q     <= '0;
            w_en_q     <= 1'b0;
            sel_q      <= '0;
            w_data_q   <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            size_q     <= '0;
            off_q      <= '0;
            unsigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            addr_q     <= addr_d;
            w_en_q     <= w_en_d;
            sel_q      <= sel_d;
            w_data_q   <= w_data_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            off_q      <= off_d;
            unsigned_q <= unsigned_d;
        end
    end

    assign lsu_ready_o     = (state_q == S_IDLE);
    assign lsu_done_o      = done_q;
    assign lsu_rdata_o     = rdata_q;
    assign lsu_misalign_o  = misalign_q;
    assign lsu_timeout_o   = timeout_q;
    assign dbus_cyc_o      = cyc_q;
    assign dbus_addr_o     = addr_q;
    assign dbus_w_en_o     = w_en_q;
    assign dbus_sel_byte_o = sel_q;
    assign dbus_w_data_o   = w_data_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed bench for dbus_master (TIMEOUT_CYCLES=4). Inputs change and outputs are sampled on negedge.
module tb_dbus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misalign_o;
    logic        lsu_timeout_o;
    logic        dbus_cyc_o;
    logic [31:0] dbus_addr_o;
    logic        dbus_w_en_o;
    logic [3:0]  dbus_sel_byte_o;
    logic [31:0] dbus_w_data_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_r_data_i;

    int checks   = 0;
    int failures = 0;

    dbus_master #(
        .XLEN(32),
        .TIMEOUT_CYCLES(4),
        .TMO_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lsu_req_i(lsu_req_i),
        .lsu_we_i(lsu_we_i),
        .lsu_addr_i(lsu_addr_i),
        .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_o),
        .lsu_done_o(lsu_done_o),
        .lsu_rdata_o(lsu_rdata_o),
        .lsu_misalign_o(lsu_misalign_o),
        .lsu_timeout_o(lsu_timeout_o),
        .dbus_cyc_o(dbus_cyc_o),
        .dbus_addr_o(dbus_addr_o),
        .dbus_w_en_o(dbus_w_en_o),
        .dbus_sel_byte_o(dbus_sel_byte_o),
        .dbus_w_data_o(dbus_w_data_o),
        .dbus_ack_i(dbus_ack_i),
        .dbus_r_data_i(dbus_r_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called on a negedge; presents a request, lets it be accepted, returns on the following negedge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_addr_i     = addr;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        lsu_wdata_i    = wd;
        chk1("ready_before_accept", lsu_ready_o, 1'b1);
        @(negedge clk);
        lsu_req_i = 1'b0;
    endtask

    // Load with ack raised in the lat-th bus cycle; checks the returned data.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] rd, input int lat,
                            input logic [31:0] exp);
        issue(1'b0, addr, size, uns, 32'h0);
        for (int i = 1; i < lat; i++) @(negedge clk);
        dbus_ack_i    = 1'b1;
        dbus_r_data_i = rd;
        @(negedge clk);
        dbus_ack_i    = 1'b0;
        dbus_r_data_i = '0;
        chk1({tag, "_done"}, lsu_done_o, 1'b1);
        chk({tag, "_rdata"}, lsu_rdata_o, exp);
        @(negedge clk);
    endtask

    logic [31:0] q_addr [3];
    int          idx;
    int          ndone;
    logic        acc_pending;

    initial begin
        rst_n          = 1'b0;
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_addr_i     = '0;
        lsu_size_i     = '0;
        lsu_unsigned_i = 1'b0;
        lsu_wdata_i    = '0;
        dbus_ack_i     = 1'b0;
        dbus_r_data_i  = '0;

        // Reset state
        #12;
        chk1("rst_cyc", dbus_cyc_o, 1'b0);
        chk1("rst_done", lsu_done_o, 1'b0);
        chk("rst_rdata", lsu_rdata_o, 32'h0);
        chk1("rst_ready", lsu_ready_o, 1'b1);
        chk("rst_addr", dbus_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: store byte, combinational ack
        issue(1'b1, 32'h8000_0003, 2'b00, 1'b0, 32'h0000_00A5);
        chk1("st_cyc", dbus_cyc_o, 1'b1);
        chk("st_addr", dbus_addr_o, 32'h8000_0000);
        chk("st_sel", 32'(dbus_sel_byte_o), 32'h8);
        chk("st_wdata", dbus_w_data_o, 32'hA5A5_A5A5);
        chk1("st_wen", dbus_w_en_o, 1'b1);
        chk1("st_done_early", lsu_done_o, 1'b0);
        chk1("st_ready_busy", lsu_ready_o, 1'b0);
        dbus_ack_i = 1'b1;
        @(negedge clk);
        dbus_ack_i = 1'b0;
        chk1("st_done", lsu_done_o, 1'b1);
        chk1("st_cyc_off", dbus_cyc_o, 1'b0);
        chk1("st_misalign", lsu_misalign_o, 1'b0);
        chk1("st_timeout", lsu_timeout_o, 1'b0);
        @(negedge clk);
        chk1("st_done_pulse", lsu_done_o, 1'b0);
        chk1("st_ready_back", lsu_ready_o, 1'b1);

        // 2: load half signed, ack in the 2nd bus cycle
        issue(1'b0, 32'h1000_0002, 2'b01, 1'b0, 32'hFFFF_FFFF);
        chk("ldh_sel", 32'(dbus_sel_byte_o), 32'hC);
        chk1("ldh_wen", dbus_w_en_o, 1'b0);
        chk("ldh_wdata", dbus_w_data_o, 32'h0);
        @(negedge clk);
        chk1("ldh_cyc_hold", dbus_cyc_o, 1'b1);
        chk1("ldh_no_done", lsu_done_o, 1'b0);
        dbus_ack_i    = 1'b1;
        dbus_r_data_i = 32'h8001_1234;
        @(negedge clk);
        dbus_ack_i    = 1'b0;
        dbus_r_data_i = '0;
        chk1("ldh_done", lsu_done_o, 1'b1);
        chk("ldh_rdata", lsu_rdata_o, 32'hFFFF_8001);
        @(negedge clk);
        chk("ldh_rdata_clr", lsu_rdata_o, 32'h0);
        run_load("ldhu", 32'h1000_0002, 2'b01, 1'b1, 32'h8001_1234, 2, 32'h0000_8001);
        run_load("ldb",  32'h1000_0001, 2'b00, 1'b0, 32'h8001_1234, 1, 32'h0000_0012);
        run_load("ldbn", 32'h1000_0003, 2'b00, 1'b0, 32'h8001_1234, 1, 32'hFFFF_FF80);
        run_load("ldw",  32'h1000_0004, 2'b10, 1'b0, 32'h8001_1234, 3, 32'h8001_1234);

        // 3: misaligned word and reserved size
        issue(1'b0, 32'h1000_0001, 2'b10, 1'b0, 32'h0);
        chk1("mis_done", lsu_done_o, 1'b1);
        chk1("mis_flag", lsu_misalign_o, 1'b1);
        chk1("mis_cyc", dbus_cyc_o, 1'b0);
        chk1("mis_ready_busy", lsu_ready_o, 1'b0);
        @(negedge clk);
        chk1("mis_ready", lsu_ready_o, 1'b1);
        chk1("mis_flag_clr", lsu_misalign_o, 1'b0);
        chk1("mis_cyc_after", dbus_cyc_o, 1'b0);
        issue(1'b1, 32'h1000_0000, 2'b11, 1'b0, 32'h0);
        chk1("rsv_flag", lsu_misalign_o, 1'b1);
        chk1("rsv_cyc", dbus_cyc_o, 1'b0);
        @(negedge clk);

        // 4: timeout after 5 bus cycles, then ack on the 5th cycle
        issue(1'b0, 32'h2000_0000, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk1("tmo_cyc_high", dbus_cyc_o, 1'b1);
            chk1("tmo_no_done", lsu_done_o, 1'b0);
            @(negedge clk);
        end
        chk1("tmo_cyc_low", dbus_cyc_o, 1'b0);
        chk1("tmo_done", lsu_done_o, 1'b1);
        chk1("tmo_flag", lsu_timeout_o, 1'b1);
        chk("tmo_rdata", lsu_rdata_o, 32'h0);
        @(negedge clk);
        chk1("tmo_flag_clr", lsu_timeout_o, 1'b0);
        run_load("tmo_ack5", 32'h2000_0000, 2'b10, 1'b0, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF);
        chk1("tmo_ack5_flag_after", lsu_timeout_o, 1'b0);
        issue(1'b0, 32'h2000_0000, 2'b10, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        dbus_ack_i    = 1'b1;
        dbus_r_data_i = 32'h0BAD_F00D;
        @(negedge clk);
        dbus_ack_i    = 1'b0;
        dbus_r_data_i = '0;
        chk1("tmo_tie_done", lsu_done_o, 1'b1);
        chk1("tmo_tie_flag", lsu_timeout_o, 1'b0);
        chk("tmo_tie_rdata", lsu_rdata_o, 32'h0BAD_F00D);
        @(negedge clk);

        // 5: asynchronous reset mid-transaction
        issue(1'b1, 32'h3000_0000, 2'b10, 1'b0, 32'h1122_3344);
        chk1("arst_cyc_before", dbus_cyc_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_cyc_drop", dbus_cyc_o, 1'b0);
        chk1("arst_ready", lsu_ready_o, 1'b1);
        @(negedge clk);
        chk1("arst_no_done", lsu_done_o, 1'b0);
        rst_n = 1'b1;
        dbus_ack_i = 1'b1;
        @(negedge clk);
        dbus_ack_i = 1'b0;
        chk1("idle_ack_ignored", lsu_done_o, 1'b0);
        chk1("arst_ready_after", lsu_ready_o, 1'b1);
        issue(1'b1, 32'h3000_0004, 2'b10, 1'b0, 32'h1122_3344);
        chk("arst_st_wdata", dbus_w_data_o, 32'h1122_3344);
        chk("arst_st_sel", 32'(dbus_sel_byte_o), 32'hF);
        chk("arst_st_addr", dbus_addr_o, 32'h3000_0004);
        dbus_ack_i = 1'b1;
        @(negedge clk);
        dbus_ack_i = 1'b0;
        chk1("arst_st_done", lsu_done_o, 1'b1);
        @(negedge clk);

        // 6: three back-to-back requests with req held high
        q_addr[0]   = 32'h0000_0200;
        q_addr[1]   = 32'h0000_0204;
        q_addr[2]   = 32'h0000_0208;
        idx         = 0;
        ndone       = 0;
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 2'b10;
        lsu_addr_i  = q_addr[0];
        acc_pending = lsu_ready_o;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            @(negedge clk);
            if (acc_pending) begin
                idx++;
                acc_pending = 1'b0;
                if (idx < 3) lsu_addr_i = q_addr[idx];
                else         lsu_req_i  = 1'b0;
            end
            dbus_ack_i    = dbus_cyc_o;
            dbus_r_data_i = dbus_addr_o ^ 32'hA5A5_0000;
            if (lsu_done_o) begin
                chk("q_order", lsu_rdata_o, q_addr[ndone] ^ 32'hA5A5_0000);
                chk1("q_cyc_gap", dbus_cyc_o, 1'b0);
                ndone++;
            end
            if (dbus_cyc_o) chk1("q_ready_busy", lsu_ready_o, 1'b0);
            if (lsu_ready_o && lsu_req_i) acc_pending = 1'b1;
        end
        dbus_ack_i    = 1'b0;
        dbus_r_data_i = '0;
        lsu_req_i     = 1'b0;
        chk("q_done_count", 32'(ndone), 32'd3);
        @(negedge clk);
        chk1("q_idle_end", lsu_ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
